conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer
//   Address sequencer for a direct convolution engine. After a start, it
//   walks filter -> centre row -> centre column -> tap row -> tap column ->
//   depth and emits one beat per tap. Each beat carries the image address,
//   the filter address and the output address, plus first/last/pad flags.
//   Beats use a valid/ready handshake.
//
//   Optional feature: define CONV_SEQ_PAD_EN to get zero-padded borders.
//   Windows then start at 0 and end at dim-1. Taps that fall outside the
//   image assert pad and drive img_addr = 0.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   start                     begin a job (only accepted in IDLE)
//   image_dim/image_depth     image x/y size and z size
//   *_memory_offset           base addresses of image, filter and output
//   filter_halfsize           h, filter side = 2h+1
//   filter_stride             window step
//   filter_length             depth*(2h+1)^2, supplied by the caller
//   num_filters               number of output channels
//   out_valid/out_ready       beat handshake
//   img_addr/filt_addr/out_addr, first, last, pad   beat payload
//   busy, done                job in progress / one-cycle end-of-job pulse
module conv_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DIM_W   = 8,
  parameter int DEPTH_W = 9,
  parameter int LEN_W   = 13,
  parameter int NF_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   image_dim,
  input  logic [DEPTH_W-1:0] image_depth,
  input  logic [ADDR_W-1:0]  image_memory_offset,
  input  logic [ADDR_W-1:0]  filter_memory_offset,
  input  logic [ADDR_W-1:0]  output_memory_offset,
  input  logic [1:0]         filter_halfsize,
  input  logic [2:0]         filter_stride,
  input  logic [LEN_W-1:0]   filter_length,
  input  logic [NF_W-1:0]    num_filters,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  img_addr,
  output logic [ADDR_W-1:0]  filt_addr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               first,
  output logic               last,
  output logic               pad,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  // Captured job configuration
  logic [DIM_W-1:0]   dim_q, dim_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  img_off_q, img_off_d;
  logic [ADDR_W-1:0]  out_off_q, out_off_d;
  logic [1:0]         h_q, h_d;
  logic [2:0]         stride_q, stride_d;
  logic [LEN_W-1:0]   flen_q, flen_d;
  logic [NF_W-1:0]    nf_q, nf_d;
  logic               empty_q, empty_d;

  // Loop counters
  logic [NF_W-1:0]    f_q, f_d;
  logic [DIM_W-1:0]   cy_q, cy_d, cx_q, cx_d;
  logic [2:0]         fy_q, fy_d, fx_q, fx_d;
  logic [DEPTH_W-1:0] z_q, z_d;
  logic [LEN_W-1:0]   tap_q, tap_d;
  logic [ADDR_W-1:0]  win_q, win_d;
  logic [ADDR_W-1:0]  fbase_q, fbase_d;  // filter_memory_offset + f*filter_length

  logic [DIM_W-1:0]   lo_start, lo;
  logic [DIM_W:0]     hi, cy_next, cx_next;
  logic [2:0]         fmax;
  logic               empty_start, fire;
  logic               z_end, fx_end, fy_end, cx_end, cy_end, f_end;
  logic [ADDR_W-1:0]  row, col, lin;
  logic               tap_pad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      dim_q     <= '0;
      depth_q   <= '0;
      img_off_q <= '0;
      out_off_q <= '0;
      h_q       <= '0;
      stride_q  <= '0;
      flen_q    <= '0;
      nf_q      <= '0;
      empty_q   <= '0;
      f_q       <= '0;
      cy_q      <= '0;
      cx_q      <= '0;
      fy_q      <= '0;
      fx_q      <= '0;
      z_q       <= '0;
      tap_q     <= '0;
      win_q     <= '0;
      fbase_q   <= '0;
    end else begin
      state_q   <= state_d;
      dim_q     <= dim_d;
      depth_q   <= depth_d;
      img_off_q <= img_off_d;
      out_off_q <= out_off_d;
      h_q       <= h_d;
      stride_q  <= stride_d;
      flen_q    <= flen_d;
      nf_q      <= nf_d;
      empty_q   <= empty_d;
      f_q       <= f_d;
      cy_q      <= cy_d;
      cx_q      <= cx_d;
      fy_q      <= fy_d;
      fx_q      <= fx_d;
      z_q       <= z_d;
      tap_q     <= tap_d;
      win_q     <= win_d;
      fbase_q   <= fbase_d;
    end
  end

  // Window centre range; a job with an empty range or no filters issues no beats
`ifdef CONV_SEQ_PAD_EN
  assign lo_start    = '0;
  assign lo          = '0;
  assign hi          = {1'b0, dim_q} - (DIM_W+1)'(1);
  assign empty_start = (image_dim == '0) || (num_filters == '0) || (image_depth == '0);
`else
  assign lo_start    = DIM_W'(filter_halfsize);
  assign lo          = DIM_W'(h_q);
  assign hi          = {1'b0, dim_q} - (DIM_W+1)'(1) - (DIM_W+1)'(h_q);
  assign empty_start = ({1'b0, image_dim} < (DIM_W+1)'({filter_halfsize, 1'b1})) ||
                       (num_filters == '0) || (image_depth == '0);
`endif

  assign fmax    = {h_q, 1'b0};
  assign cy_next = {1'b0, cy_q} + (DIM_W+1)'(stride_q);
  assign cx_next = {1'b0, cx_q} + (DIM_W+1)'(stride_q);
  assign z_end   = (z_q == depth_q - DEPTH_W'(1));
  assign fx_end  = (fx_q == fmax);
  assign fy_end  = (fy_q == fmax);
  assign cx_end  = (cx_next > hi);
  assign cy_end  = (cy_next > hi);
  assign f_end   = (f_q == nf_q - NF_W'(1));

  assign out_valid = (state_q == S_RUN) && !empty_q;
  assign fire      = out_valid && out_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    dim_d     = dim_q;
    depth_d   = depth_q;
    img_off_d = img_off_q;
    out_off_d = out_off_q;
    h_d       = h_q;
    stride_d  = stride_q;
    flen_d    = flen_q;
    nf_d      = nf_q;
    empty_d   = empty_q;
    f_d       = f_q;
    cy_d      = cy_q;
    cx_d      = cx_q;
    fy_d      = fy_q;
    fx_d      = fx_q;
    z_d       = z_q;
    tap_d     = tap_q;
    win_d     = win_q;
    fbase_d   = fbase_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          dim_d     = image_dim;
          depth_d   = image_depth;
          img_off_d = image_memory_offset;
          out_off_d = output_memory_offset;
          h_d       = filter_halfsize;
          stride_d  = filter_stride;
          flen_d    = filter_length;
          nf_d      = num_filters;
          empty_d   = empty_start;
          f_d       = '0;
          cy_d      = lo_start;
          cx_d      = lo_start;
          fy_d      = '0;
          fx_d      = '0;
          z_d       = '0;
          tap_d     = '0;
          win_d     = '0;
          fbase_d   = filter_memory_offset;
        end
      end
      S_RUN: begin
        if (empty_q) begin
          state_d = S_DONE;
        end else if (fire) begin
          // Odometer carry chain: z -> fx -> fy -> cx -> cy -> f
          tap_d = tap_q + LEN_W'(1);
          z_d   = z_q + DEPTH_W'(1);
          if (z_end) begin
            z_d  = '0;
            fx_d = fx_q + 3'd1;
            if (fx_end) begin
              fx_d = '0;
              fy_d = fy_q + 3'd1;
              if (fy_end) begin
                fy_d  = '0;
                tap_d = '0;
                win_d = win_q + ADDR_W'(1);
                cx_d  = cx_next[DIM_W-1:0];
                if (cx_end) begin
                  cx_d = lo;
                  cy_d = cy_next[DIM_W-1:0];
                  if (cy_end) begin
                    cy_d    = lo;
                    f_d     = f_q + NF_W'(1);
                    fbase_d = fbase_q + ADDR_W'(flen_q);
                    if (f_end) state_d = S_DONE;
                  end
                end
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Image coordinates of the current tap, modulo 2^ADDR_W
  assign row = ADDR_W'(cy_q) + ADDR_W'(fy_q) - ADDR_W'(h_q);
  assign col = ADDR_W'(cx_q) + ADDR_W'(fx_q) - ADDR_W'(h_q);
  assign lin = (row * ADDR_W'(dim_q) + col) * ADDR_W'(depth_q) + ADDR_W'(z_q);

`ifdef CONV_SEQ_PAD_EN
  logic [DIM_W:0] rsum, csum;
  logic           pad_row, pad_col;
  assign rsum    = {1'b0, cy_q} + (DIM_W+1)'(fy_q);
  assign csum    = {1'b0, cx_q} + (DIM_W+1)'(fx_q);
  assign pad_row = (rsum < (DIM_W+1)'(h_q)) || ((rsum - (DIM_W+1)'(h_q)) >= {1'b0, dim_q});
  assign pad_col = (csum < (DIM_W+1)'(h_q)) || ((csum - (DIM_W+1)'(h_q)) >= {1'b0, dim_q});
  assign tap_pad = pad_row || pad_col;
`else
  assign tap_pad = 1'b0;
`endif

  // Beat payload is forced to zero whenever no beat is presented
  assign img_addr  = (out_valid && !tap_pad) ? img_off_q + lin : '0;
  assign filt_addr = out_valid ? fbase_q + ADDR_W'(tap_q) : '0;
  assign out_addr  = out_valid ? out_off_q + win_q : '0;
  assign first     = out_valid && (tap_q == '0);
  assign last      = out_valid && (tap_q == flen_q - LEN_W'(1));
  assign pad       = out_valid && tap_pad;

endmodule

// File: tb/tb_conv_sequencer.sv
// Testbench for conv_sequencer (default parameters). Stimulus pushes the
// expected beat stream from a loop-nest reference model into a queue; a
// monitor pops and compares on each handshake. Directed anchor values are
// checked against hand-computed constants. Builds for both settings of
// CONV_SEQ_PAD_EN.
module tb_conv_sequencer;

  typedef struct packed {
    logic [15:0] img;
    logic [15:0] filt;
    logic [15:0] oa;
    logic        first;
    logic        last;
    logic        pad;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  image_dim;
  logic [8:0]  image_depth;
  logic [15:0] image_memory_offset, filter_memory_offset, output_memory_offset;
  logic [1:0]  filter_halfsize;
  logic [2:0]  filter_stride;
  logic [12:0] filter_length;
  logic [3:0]  num_filters;
  logic        out_valid, out_ready;
  logic [15:0] img_addr, filt_addr, out_addr;
  logic        first, last, pad, busy, done;

  conv_sequencer #(.ADDR_W(16), .DIM_W(8), .DEPTH_W(9), .LEN_W(13), .NF_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .image_dim(image_dim), .image_depth(image_depth),
    .image_memory_offset(image_memory_offset),
    .filter_memory_offset(filter_memory_offset),
    .output_memory_offset(output_memory_offset),
    .filter_halfsize(filter_halfsize), .filter_stride(filter_stride),
    .filter_length(filter_length), .num_filters(num_filters),
    .out_valid(out_valid), .out_ready(out_ready),
    .img_addr(img_addr), .filt_addr(filt_addr), .out_addr(out_addr),
    .first(first), .last(last), .pad(pad), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t exp_q[$];
  beat_t act_log[$];
  int    n_checks = 0, n_fail = 0;
  int    beats_seen = 0, last_hs_cyc = 0, stall_checks = 0;
  bit    prev_stall = 1'b0;
  beat_t held;

  function automatic beat_t cur_beat();
    return {img_addr, filt_addr, out_addr, first, last, pad};
  endfunction

  function automatic beat_t logv(input int idx);
    if (idx < act_log.size()) return act_log[idx];
    return '1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: scoreboard pop on handshake, stability check while stalled
  always @(negedge clk) begin
    beat_t a, e;
    a = cur_beat();
    if (prev_stall && out_valid) begin
      n_checks++;
      stall_checks++;
      if (a !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got img=%0d filt=%0d out=%0d flp=%b%b%b expected img=%0d filt=%0d out=%0d flp=%b%b%b",
                 a.img, a.filt, a.oa, a.first, a.last, a.pad, held.img, held.filt, held.oa, held.first, held.last, held.pad);
      end
    end
    prev_stall = out_valid && !out_ready;
    held = a;
    if (out_valid && out_ready) begin
      n_checks++;
      last_hs_cyc = cyc;
      act_log.push_back(a);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat[%0d]: got img=%0d filt=%0d out=%0d expected no beat", beats_seen, a.img, a.filt, a.oa);
      end else begin
        e = exp_q.pop_front();
        if (a !== e)begin
          n_fail++;
          $display("FAIL beat[%0d]: got img=%0d filt=%0d out=%0d flp=%b%b%b expected img=%0d filt=%0d out=%0d flp=%b%b%b",
                   beats_seen, a.img, a.filt, a.oa, a.first, a.last, a.pad, e.img, e.filt, e.oa, e.first, e.last, e.pad);
        end
      end
      beats_seen++;
    end
  end

  // Reference loop nest producing the expected beat stream
  task automatic gen(input int dim, input int depth, input int h, input int stride, input int nf,
                     input int ioff, input int foff, input int ooff);
    int lo, hi, flen, win, tap, r, c;
    beat_t b;
    bit p;
    flen = depth * (2*h+1) * (2*h+1);
    win = 0;
`ifdef CONV_SEQ_PAD_EN
    lo = 0; hi = dim - 1;
`else
    lo = h; hi = dim - 1 - h;
`endif
    for (int f = 0; f < nf; f++)
      for (int cy = lo; cy <= hi; cy += stride)
        for (int cx = lo; cx <= hi; cx += stride) begin
          tap = 0;
          for (int fy = 0; fy <= 2*h; fy++)
            for (int fx = 0; fx <= 2*h; fx++)
              for (int z = 0; z < depth; z++) begin
                r = cy + fy - h;
                c = cx + fx - h;
                p = (r < 0) || (r >= dim) || (c < 0) || (c >= dim);
                b.img   = p ? 16'd0 : 16'(ioff + (r*dim + c)*depth + z);
                b.filt  = 16'(foff + f*flen + tap);
                b.oa    = 16'(ooff + win);
                b.first = (tap == 0);
                b.last  = (tap == flen - 1);
                b.pad   = p;
                exp_q.push_back(b);
                tap++;
              end
          win++;
        end
  endtask

  task automatic start_job(input int dim, input int depth, input int h, input int stride, input int nf,
                           input int ioff, input int foff, input int ooff, output int nexp);
    exp_q.delete();
    act_log.delete();
    beats_seen = 0;
    gen(dim, depth, h, stride, nf, ioff, foff, ooff);
    nexp = exp_q.size();
    @(posedge clk); #1;
    image_dim            = 8'(dim);
    image_depth          = 9'(depth);
    filter_halfsize      = 2'(h);
    filter_stride        = 3'(stride);
    num_filters          = 4'(nf);
    filter_length        = 13'(depth * (2*h+1) * (2*h+1));
    image_memory_offset  = 16'(ioff);
    filter_memory_offset = 16'(foff);
    output_memory_offset = 16'(ooff);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Disturb the config inputs: the running job must not see this
    image_dim = 8'd9; image_depth = 9'd2; filter_stride = 3'd3; num_filters = 4'd7;
    filter_length = 13'd50; image_memory_offset = 16'd333;
    filter_memory_offset = 16'd444; output_memory_offset = 16'd555;
    check("busy_after_start", busy, 1);
    if (nexp > 0) check("valid_after_start", out_valid, 1);
  endtask

  task automatic wait_done(input int nexp, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check("done_seen", found, 1);
    if (found) begin
      check("done_valid_low", out_valid, 0);
      check("done_busy", busy, 1);
      check("beat_count_model", beats_seen, nexp);
      check("queue_drained", exp_q.size(), 0);
      if (nexp > 0) check("done_latency", cyc - last_hs_cyc, 1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int n, npad, base;
    beat_t b;
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    image_dim = '0; image_depth = '0; filter_halfsize = '0; filter_stride = '0;
    filter_length = '0; num_filters = '0;
    image_memory_offset = '0; filter_memory_offset = '0; output_memory_offset = '0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addrs", {img_addr, filt_addr, out_addr}, 0);
    check("rst_flags", {first, last, pad}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

`ifndef CONV_SEQ_PAD_EN
    // dim5 depth3 h1 stride1 nf1
    start_job(5, 3, 1, 1, 1, 0, 1000, 1100, n);
    wait_done(n, 2000);
    check("a_beats", beats_seen, 243);
    b = logv(0);   check("a_first_img", b.img, 0); check("a_first_flag", b.first, 1);
    b = logv(26);  check("a_filt26", b.filt, 1026); check("a_last26", b.last, 1);
    b = logv(27);  check("a_filt27", b.filt, 1000); check("a_out27", b.oa, 1101);
    b = logv(242); check("a_last_img", b.img, 74); check("a_last_out", b.oa, 1108);

    // stride 2, plus a start pulse while running that must be ignored
    start_job(5, 3, 1, 2, 1, 0, 1000, 1100, n);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n, 1000);
    check("b_beats", beats_seen, 108);
    b = logv(27);  check("b_win2_img", b.img, 6); check("b_win2_out", b.oa, 1101);
    b = logv(107); check("b_last_out", b.oa, 1103);

    // two filters
    start_job(5, 3, 1, 1, 2, 0, 1000, 1100, n);
    wait_done(n, 2000);
    check("c_beats", beats_seen, 486);
    b = logv(243); check("c_f1_filt", b.filt, 1027); check("c_f1_out", b.oa, 1109);
    b = logv(485); check("c_last_filt", b.filt, 1053); check("c_last_out", b.oa, 1117);

    // three-cycle ready stall at beat 10
    start_job(5, 3, 1, 1, 1, 0, 1000, 1100, n);
    for (int i = 0; i < 100; i++) begin
      if (beats_seen >= 10) break;
      @(posedge clk); #1;
    end
    check("d_reached_10", beats_seen, 10);
    base = stall_checks;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("d_stall_frozen_cycles", stall_checks - base, 3);
    wait_done(n, 2000);
    check("d_beats", beats_seen, 243);

    // reset mid-job, then restart
    start_job(5, 3, 1, 1, 1, 0, 1000, 1100, n);
    for (int i = 0; i < 200; i++) begin
      if (beats_seen >= 50) break;
      @(posedge clk); #1;
    end
    check("e_reached_50", beats_seen, 50);
    rst = 1'b0;
    #1;
    check("e_rst_ctrl", {out_valid, busy, done}, 0);
    check("e_rst_addrs", {img_addr, filt_addr, out_addr}, 0);
    check("e_rst_flags", {first, last, pad}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("e_rst_hold_valid", out_valid, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("e_post_rst_idle", {out_valid, busy}, 0);
    end
    start_job(5, 3, 1, 1, 1, 0, 1000, 1100, n);
    wait_done(n, 2000);
    check("e_beats", beats_seen, 243);
    b = logv(242); check("e_last_img", b.img, 74); check("e_last_out", b.oa, 1108);

    // image smaller than the filter: zero beats
    start_job(2, 3, 1, 1, 1, 0, 1000, 1100, n);
    check("f_model_empty", n, 0);
    wait_done(n, 20);
    check("f_beats", beats_seen, 0);
`else
    // zero-padded borders
    start_job(5, 3, 1, 1, 1, 0, 1000, 1100, n);
    wait_done(n, 3000);
    check("p_beats", beats_seen, 675);
    npad = 0;
    for (int i = 0; i < 27; i++) begin
      b = logv(i);
      if (b.pad === 1'b1) npad++;
    end
    check("p_win0_pads", npad, 15);
    b = logv(0);   check("p_first_pad", {b.pad, b.img}, {1'b1, 16'd0});
    b = logv(674); check("p_last_out", b.oa, 1124); check("p_last_pad", b.pad, 1);
`endif

    // no filters: zero beats
    start_job(5, 3, 1, 1, 0, 0, 1000, 1100, n);
    wait_done(n, 20);
    check("g_beats", beats_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
